// File: rtl/arp_packet_generator_package.sv
// Shared types and Ethernet/ARP frame constants for the ARP frame generator.
package arp_packet_generator_package;

   typedef logic [47:0] mac_address;
   typedef logic [31:0] ip_address;
   typedef logic [15:0] arp_operator;

   // Generator sequencing states, in transmit order.
   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_SFD,
      S_DATA,
      S_FCS,
      S_IFG
   } arp_gen_state_t;

   localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
   localparam logic [7:0]  SFD_BYTE       = 8'hD5;
   localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
   localparam logic [15:0] HTYPE_ETHERNET = 16'h0001;
   localparam logic [15:0] PTYPE_IPV4     = 16'h0800;
   localparam logic [7:0]  HLEN_ETHERNET  = 8'h06;
   localparam logic [7:0]  PLEN_IPV4      = 8'h04;

   localparam arp_operator ARP_OP_REQUEST = 16'h0001;
   localparam mac_address  BROADCAST_MAC  = 48'hFFFF_FFFF_FFFF;

   localparam int PREAMBLE_LEN    = 7;
   localparam int DATA_LEN        = 60;
   localparam int FCS_LEN         = 4;
   // Header plus ARP payload bytes; everything after this up to DATA_LEN is padding.
   localparam int ARP_FIELD_BYTES = 42;

endpackage

// File: rtl/crc_32_byte_package.sv
// Byte-wise Ethernet CRC-32 (reflected polynomial 0xEDB88320).
package crc_32_byte_package;

   localparam logic [31:0] CRC_32_POLY = 32'hEDB8_8320;
   localparam logic [31:0] CRC_32_INIT = 32'hFFFF_FFFF;

   // Advance the running CRC by one byte, LSB of the byte first.
   function automatic logic [31:0] crc_32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
      logic [31:0] c;
      c = crc_in ^ {24'h00_0000, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_32_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/arp_packet_generator_core.sv
// ARP frame generator: emits preamble, SFD, 60-byte Ethernet II ARP frame and
// FCS as a GMII byte stream, one frame per request, back-to-back while req
// stays high. Optional feature macro: ARP_GEN_BUSY_EN adds the busy output.
// rst_n is a synchronous, active-high reset despite its name.
module arp_packet_generator_core
   import arp_packet_generator_package::*;
   import crc_32_byte_package::*;
#(
   parameter int IFG_CYCLES = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  mac_address  src_mac_add,
   input  mac_address  des_mac_add,
   input  ip_address   src_ip_add,
   input  ip_address   des_ip_add,
   input  arp_operator operator,
   input  logic        req,
   output logic        gmii_tx_en,
   output logic [7:0]  gmii_txd
`ifdef ARP_GEN_BUSY_EN
   ,output logic       busy
`endif
);

   // Data bytes are selected from a 64-slot packed array so a 6-bit index
   // always lands in range; slots 60..63 are never transmitted.
   localparam int DATA_SLOTS = 64;

   localparam logic [7:0] PREAMBLE_LAST = 8'(PREAMBLE_LEN - 1);
   localparam logic [7:0] DATA_LAST     = 8'(DATA_LEN - 1);
   localparam logic [7:0] FCS_LAST      = 8'(FCS_LEN - 1);
   localparam logic [7:0] IFG_LAST      = 8'(IFG_CYCLES - 1);

   arp_gen_state_t state, state_nxt;
   logic [7:0]     cnt, cnt_nxt;
   logic [31:0]    crc, crc_nxt;
   logic           tx_en_nxt;
   logic [7:0]     txd_nxt;
   logic           latch_en;

   // Frame register: snapshot of the request taken when it is accepted.
   mac_address     src_mac_q;
   mac_address     des_mac_q;
   ip_address      src_ip_q;
   ip_address      des_ip_q;
   arp_operator    op_q;

   mac_address     eth_dest;
   mac_address     arp_tha;
   logic [0:DATA_SLOTS-1][7:0] data_arr;
   logic [7:0]     data_byte;
   logic [31:0]    fcs_word;
   logic [7:0]     fcs_byte;

   // An ARP request is broadcast and carries an unknown (zero) target MAC.
   assign eth_dest = (op_q == ARP_OP_REQUEST) ? BROADCAST_MAC : des_mac_q;
   assign arp_tha  = (op_q == ARP_OP_REQUEST) ? 48'h0 : des_mac_q;

   // Slot 0 is the first byte on the wire; every field is MSB byte first.
   assign data_arr = {eth_dest, src_mac_q, ETHERTYPE_ARP,
                      HTYPE_ETHERNET, PTYPE_IPV4, HLEN_ETHERNET, PLEN_IPV4,
                      op_q, src_mac_q, src_ip_q, arp_tha, des_ip_q,
                      {(DATA_SLOTS - ARP_FIELD_BYTES){8'h00}}};

   assign data_byte = data_arr[cnt[5:0]];
   assign fcs_word  = ~crc;

   // FCS goes out least-significant byte first.
   always_comb begin
      fcs_byte = fcs_word[7:0];
      case (cnt[1:0])
         2'd1:    fcs_byte = fcs_word[15:8];
         2'd2:    fcs_byte = fcs_word[23:16];
         2'd3:    fcs_byte = fcs_word[31:24];
         default: fcs_byte = fcs_word[7:0];
      endcase
   end

   // Next-state, next output byte and CRC update for the frame sequencer.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      crc_nxt   = crc;
      tx_en_nxt = 1'b0;
      txd_nxt   = 8'h00;
      latch_en  = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) begin
               latch_en  = 1'b1;
               state_nxt = S_PREAMBLE;
               cnt_nxt   = 8'd0;
               crc_nxt   = CRC_32_INIT;
            end
         end
         S_PREAMBLE: begin
            tx_en_nxt = 1'b1;
            txd_nxt   = PREAMBLE_BYTE;
            if (cnt == PREAMBLE_LAST) begin
               state_nxt = S_SFD;
               cnt_nxt   = 8'd0;
            end else begin
               cnt_nxt   = cnt + 8'd1;
            end
         end
         S_SFD: begin
            tx_en_nxt = 1'b1;
            txd_nxt   = SFD_BYTE;
            state_nxt = S_DATA;
            cnt_nxt   = 8'd0;
         end
         S_DATA: begin
            // CRC absorbs each byte on the same edge that puts it on the wire.
            tx_en_nxt = 1'b1;
            txd_nxt   = data_byte;
            crc_nxt   = crc_32_byte(crc, data_byte);
            if (cnt == DATA_LAST) begin
               state_nxt = S_FCS;
               cnt_nxt   = 8'd0;
            end else begin
               cnt_nxt   = cnt + 8'd1;
            end
         end
         S_FCS: begin
            tx_en_nxt = 1'b1;
            txd_nxt   = fcs_byte;
            if (cnt == FCS_LAST) begin
               state_nxt = (IFG_CYCLES == 0) ? S_IDLE : S_IFG;
               cnt_nxt   = 8'd0;
            end else begin
               cnt_nxt   = cnt + 8'd1;
            end
         end
         S_IFG: begin
            if (cnt == IFG_LAST) begin
               state_nxt = S_IDLE;
               cnt_nxt   = 8'd0;
            end else begin
               cnt_nxt   = cnt + 8'd1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = 8'd0;
         end
      endcase
   end

   // State and byte counter register; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state <= S_IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Registered GMII outputs and running CRC.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         gmii_tx_en <= 1'b0;
         gmii_txd   <= 8'h00;
         crc        <= CRC_32_INIT;
      end else begin
         gmii_tx_en <= tx_en_nxt;
         gmii_txd   <= txd_nxt;
         crc        <= crc_nxt;
      end
   end

   // Capture the request fields so later input changes cannot corrupt the frame.
   always_ff @(posedge clk) begin
      if (latch_en) begin
         src_mac_q <= src_mac_add;
         des_mac_q <= des_mac_add;
         src_ip_q  <= src_ip_add;
         des_ip_q  <= des_ip_add;
         op_q      <= operator;
      end
   end

`ifdef ARP_GEN_BUSY_EN
   assign busy = (state != S_IDLE);
`endif

endmodule

// File: tb/tb_arp_packet_generator_core.sv
// Self-checking bench for arp_packet_generator_core: frames are compared
// against a byte-level reference model of the ARP frame and its CRC-32.
module tb_arp_packet_generator_core;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic [47:0] src_mac_add, des_mac_add;
   logic [31:0] src_ip_add, des_ip_add;
   logic [15:0] operator;
   logic        gmii_tx_en;
   logic [7:0]  gmii_txd;
`ifdef ARP_GEN_BUSY_EN
   logic        busy;
`endif

   logic [47:0] p_src, p_dst;
   logic [31:0] p_sip, p_dip;
   logic [15:0] p_op;

   logic [7:0]  got   [72];
   logic [7:0]  exp_b [72];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;

   arp_packet_generator_core #(.IFG_CYCLES(12)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .src_mac_add (src_mac_add),
      .des_mac_add (des_mac_add),
      .src_ip_add  (src_ip_add),
      .des_ip_add  (des_ip_add),
      .operator    (operator),
      .req         (req),
      .gmii_tx_en  (gmii_tx_en),
      .gmii_txd    (gmii_txd)
`ifdef ARP_GEN_BUSY_EN
      ,.busy       (busy)
`endif
   );

   initial clk = 1'b0;
   always #4 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic set_inputs(input logic [47:0] s, input logic [47:0] d,
                             input logic [31:0] si, input logic [31:0] di,
                             input logic [15:0] op);
      src_mac_add = s; des_mac_add = d;
      src_ip_add  = si; des_ip_add = di;
      operator    = op;
   endtask

   task automatic apply_pending();
      set_inputs(p_src, p_dst, p_sip, p_dip, p_op);
   endtask

   task automatic randomize_pending();
      p_src = {16'($urandom), $urandom};
      p_dst = {16'($urandom), $urandom};
      p_sip = $urandom;
      p_dip = $urandom;
      case ($urandom_range(0, 2))
         0:       p_op = 16'h0001;
         1:       p_op = 16'h0002;
         default: p_op = 16'($urandom);
      endcase
   endtask

   // Reference frame: preamble, SFD, 60 data bytes, FCS (bit-serial CRC-32).
   task automatic model_frame(input logic [47:0] s, input logic [47:0] d,
                              input logic [31:0] si, input logic [31:0] di,
                              input logic [15:0] op);
      logic [7:0]  db [60];
      logic [31:0] c;
      logic        fb;
      for (int i = 0; i < 60; i++) db[i] = 8'h00;
      for (int i = 0; i < 6; i++) begin
         db[i]      = (op == 16'h0001) ? 8'hFF : d[47-8*i -: 8];
         db[6+i]    = s[47-8*i -: 8];
         db[22+i]   = s[47-8*i -: 8];
         db[32+i]   = (op == 16'h0001) ? 8'h00 : d[47-8*i -: 8];
      end
      db[12] = 8'h08; db[13] = 8'h06; db[14] = 8'h00; db[15] = 8'h01;
      db[16] = 8'h08; db[17] = 8'h00; db[18] = 8'h06; db[19] = 8'h04;
      db[20] = op[15:8]; db[21] = op[7:0];
      for (int i = 0; i < 4; i++) begin
         db[28+i] = si[31-8*i -: 8];
         db[38+i] = di[31-8*i -: 8];
      end
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < 60; i++) begin
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ db[i][b];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB8_8320;
         end
      end
      c = ~c;
      for (int i = 0; i < 7; i++) exp_b[i] = 8'h55;
      exp_b[7] = 8'hD5;
      for (int i = 0; i < 60; i++) exp_b[8+i] = db[i];
      for (int k = 0; k < 4; k++) exp_b[68+k] = c[8*k +: 8];
   endtask

   function automatic logic [575:0] pack_got();
      logic [575:0] v;
      for (int i = 0; i < 72; i++) v[575-8*i -: 8] = got[i];
      return v;
   endfunction

   function automatic logic [575:0] pack_exp();
      logic [575:0] v;
      for (int i = 0; i < 72; i++) v[575-8*i -: 8] = exp_b[i];
      return v;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Wait (bounded) for tx_en and record up to 72 bytes. At byte hook_idx an
   // action runs: 1 = load pending inputs, 2 = drop req, 3 = assert reset and stop.
   task automatic capture(input int hook_idx, input int hook_kind,
                          output bit started, output bit en_ok,
                          output int start_cyc, output int wait_n);
      started = 1'b0; en_ok = 1'b1; wait_n = 0; start_cyc = 0;
      for (int i = 0; i < 72; i++) got[i] = 8'hXX;
      for (int k = 0; k < 300 && !started; k++) begin
         @(negedge clk);
         wait_n++;
         if (gmii_tx_en === 1'b1) started = 1'b1;
      end
      if (!started) return;
      start_cyc = cyc;
      for (int i = 0; i < 72; i++) begin
         if (i > 0) @(negedge clk);
         got[i] = gmii_txd;
         if (gmii_tx_en !== 1'b1) en_ok = 1'b0;
         if (i == hook_idx) begin
            case (hook_kind)
               1: apply_pending();
               2: req = 1'b0;
               3: begin rst_n = 1'b1; return; end
               default: ;
            endcase
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1; req = 1'b1;
      set_inputs(48'h1, 48'h2, 32'h3, 32'h4, 16'h2);
      repeat (3) @(negedge clk);
      n_checks++;
      if (gmii_tx_en !== 1'b0) $display("FAIL reset_tx_en got=%b exp=0", gmii_tx_en);
      else n_pass++;
      n_checks++;
      if (gmii_txd !== 8'h00) $display("FAIL reset_txd got=%h exp=00", gmii_txd);
      else n_pass++;
`ifdef ARP_GEN_BUSY_EN
      n_checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy);
      else n_pass++;
`endif
      req = 1'b0; rst_n = 1'b0;
      idle(6);
      n_checks++;
      if (gmii_tx_en !== 1'b0) $display("FAIL idle_no_req got=%b exp=0", gmii_tx_en);
      else n_pass++;
   endtask

   task automatic test_known_vector();
      bit started, en_ok; int t0, wn, highs;
      logic [63:0] pre; logic [7:0] pad_or;
      set_inputs(48'hAABB_CCDD_EEFF, 48'h0011_2233_4455, 32'hC0A8_0101, 32'hC0A8_0164, 16'h0002);
      req = 1'b1;
      capture(10, 2, started, en_ok, t0, wn);
      model_frame(48'hAABB_CCDD_EEFF, 48'h0011_2233_4455, 32'hC0A8_0101, 32'hC0A8_0164, 16'h0002);
      n_checks++;
      if (!started) $display("FAIL kv_start got=timeout exp=frame");
      else n_pass++;
      n_checks++;
      if (wn !== 2) $display("FAIL kv_latency got=%0d exp=2", wn);
      else n_pass++;
      n_checks++;
      if (!en_ok) $display("FAIL kv_tx_en_span got=gap exp=72 contiguous");
      else n_pass++;
      n_checks++;
      if (pack_got() !== pack_exp()) $display("FAIL kv_frame got=%h exp=%h", pack_got(), pack_exp());
      else n_pass++;
      for (int i = 0; i < 8; i++) pre[63-8*i -: 8] = got[i];
      n_checks++;
      if (pre !== 64'h5555_5555_5555_55D5) $display("FAIL kv_preamble got=%h exp=55555555555555d5", pre);
      else n_pass++;
      n_checks++;
      if ({got[20], got[21]} !== 16'h0806) $display("FAIL kv_ethertype got=%h exp=0806", {got[20], got[21]});
      else n_pass++;
      n_checks++;
      if ({got[28], got[29]} !== 16'h0002) $display("FAIL kv_opcode got=%h exp=0002", {got[28], got[29]});
      else n_pass++;
      pad_or = 8'h00;
      for (int i = 50; i < 68; i++) pad_or = pad_or | got[i];
      n_checks++;
      if (pad_or !== 8'h00) $display("FAIL kv_padding got=%h exp=00", pad_or);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00)
         $display("FAIL kv_after_frame got=%b/%h exp=0/00", gmii_tx_en, gmii_txd);
      else n_pass++;
      highs = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (gmii_tx_en === 1'b1) highs++;
      end
      n_checks++;
      if (highs != 0) $display("FAIL kv_req_dropped got=%0d exp=0 active cycles", highs);
      else n_pass++;
   endtask

   task automatic test_opcode_request();
      bit started, en_ok; int t0, wn;
      logic [47:0] eth_d, tha;
      randomize_pending();
      p_op = 16'h0001;
      apply_pending();
      req = 1'b1;
      capture(0, 2, started, en_ok, t0, wn);
      model_frame(p_src, p_dst, p_sip, p_dip, p_op);
      for (int i = 0; i < 6; i++) begin
         eth_d[47-8*i -: 8] = got[8+i];
         tha[47-8*i -: 8]   = got[40+i];
      end
      n_checks++;
      if (!started || !en_ok) $display("FAIL req_op_span got=%b/%b exp=1/1", started, en_ok);
      else n_pass++;
      n_checks++;
      if (eth_d !== 48'hFFFF_FFFF_FFFF) $display("FAIL req_op_dest got=%h exp=ffffffffffff", eth_d);
      else n_pass++;
      n_checks++;
      if (tha !== 48'h0) $display("FAIL req_op_tha got=%h exp=000000000000", tha);
      else n_pass++;
      n_checks++;
      if (pack_got() !== pack_exp()) $display("FAIL req_op_frame got=%h exp=%h", pack_got(), pack_exp());
      else n_pass++;
      idle(20);
   endtask

   task automatic test_random_frames();
      bit started, en_ok; int t0, wn;
      for (int n = 0; n < 5; n++) begin
         randomize_pending();
         apply_pending();
         req = 1'b1;
         capture(0, 2, started, en_ok, t0, wn);
         model_frame(p_src, p_dst, p_sip, p_dip, p_op);
         n_checks++;
         if (!started || !en_ok || pack_got() !== pack_exp())
            $display("FAIL rand_frame_%0d got=%h exp=%h", n, pack_got(), pack_exp());
         else n_pass++;
         idle(20);
      end
   endtask

   task automatic test_back_to_back();
      bit started, en_ok; int t1, t2, wn, highs;
      logic [47:0] a_src, a_dst; logic [31:0] a_sip, a_dip; logic [15:0] a_op;
      randomize_pending();
      a_src = p_src; a_dst = p_dst; a_sip = p_sip; a_dip = p_dip; a_op = p_op;
      apply_pending();
      randomize_pending();
      req = 1'b1;
      capture(20, 1, started, en_ok, t1, wn);
      model_frame(a_src, a_dst, a_sip, a_dip, a_op);
      n_checks++;
      if (!started || !en_ok || pack_got() !== pack_exp())
         $display("FAIL b2b_frame1 got=%h exp=%h", pack_got(), pack_exp());
      else n_pass++;
      capture(5, 2, started, en_ok, t2, wn);
      model_frame(p_src, p_dst, p_sip, p_dip, p_op);
      n_checks++;
      if (wn - 1 !== 13) $display("FAIL b2b_gap got=%0d exp=13", wn - 1);
      else n_pass++;
      n_checks++;
      if (t2 - t1 !== 85) $display("FAIL b2b_period got=%0d exp=85", t2 - t1);
      else n_pass++;
      n_checks++;
      if (!started || !en_ok || pack_got() !== pack_exp())
         $display("FAIL b2b_frame2 got=%h exp=%h", pack_got(), pack_exp());
      else n_pass++;
      highs = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (gmii_tx_en === 1'b1) highs++;
      end
      n_checks++;
      if (highs != 0) $display("FAIL b2b_stop got=%0d exp=0 active cycles", highs);
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      bit started, en_ok; int t0, wn;
      randomize_pending();
      apply_pending();
      req = 1'b1;
      capture(38, 3, started, en_ok, t0, wn);
      model_frame(p_src, p_dst, p_sip, p_dip, p_op);
      n_checks++;
      if (!started || got[38] !== exp_b[38])
         $display("FAIL rst_mid_byte30 got=%h exp=%h", got[38], exp_b[38]);
      else n_pass++;
      randomize_pending();
      apply_pending();
      @(negedge clk);
      n_checks++;
      if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00)
         $display("FAIL rst_mid_abort got=%b/%h exp=0/00", gmii_tx_en, gmii_txd);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b0;
      capture(0, 2, started, en_ok, t0, wn);
      model_frame(p_src, p_dst, p_sip, p_dip, p_op);
      n_checks++;
      if (!started || !en_ok || pack_got() !== pack_exp())
         $display("FAIL rst_mid_next_frame got=%h exp=%h", pack_got(), pack_exp());
      else n_pass++;
      idle(20);
   endtask

`ifdef ARP_GEN_BUSY_EN
   task automatic test_busy();
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL busy_idle got=%b exp=0", busy);
      else n_pass++;
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL busy_accepted got=%b exp=1", busy);
      else n_pass++;
      idle(100);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL busy_done got=%b exp=0", busy);
      else n_pass++;
   endtask
`endif

   initial begin
      rst_n = 1'b1;
      req   = 1'b0;
      set_inputs(48'h0, 48'h0, 32'h0, 32'h0, 16'h0);
      p_src = 48'h0; p_dst = 48'h0; p_sip = 32'h0; p_dip = 32'h0; p_op = 16'h0;
      test_reset();
      test_known_vector();
      test_opcode_request();
      test_random_frames();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef ARP_GEN_BUSY_EN
      test_busy();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
